// File: rtl/secret_accum_array_if.sv
// rtl/secret_accum_array_if.sv - Signal bundle for the multi-channel accumulator and delay line
//
// master drives: accum_in, accum_en, accum_clear, accum_bypass, dly_in, dly_valid_in
// slave drives : accum_out, accum_bypass_out, overflow, dly_out, dly_valid_out, dly_pending
// Channel i of any NCH*WIDTH vector occupies bits [i*WIDTH +: WIDTH].
interface secret_accum_array_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 3
);
    localparam int PW = $clog2(DEPTH + 1);

    logic [NCH*WIDTH-1:0] accum_in;
    logic [NCH-1:0]       accum_en;
    logic [NCH-1:0]       accum_clear;
    logic [NCH-1:0]       accum_bypass;
    logic [NCH*WIDTH-1:0] accum_out;
    logic [NCH*WIDTH-1:0] accum_bypass_out;
    logic [NCH-1:0]       overflow;
    logic [WIDTH-1:0]     dly_in;
    logic                 dly_valid_in;
    logic [WIDTH-1:0]     dly_out;
    logic                 dly_valid_out;
    logic [PW-1:0]        dly_pending;

    modport master (
        output accum_in, accum_en, accum_clear, accum_bypass, dly_in, dly_valid_in,
        input  accum_out, accum_bypass_out, overflow, dly_out, dly_valid_out, dly_pending
    );

    modport slave (
        input  accum_in, accum_en, accum_clear, accum_bypass, dly_in, dly_valid_in,
        output accum_out, accum_bypass_out, overflow, dly_out, dly_valid_out, dly_pending
    );
endinterface

// File: rtl/secret_accum_array.sv
// rtl/secret_accum_array.sv - NCH independent WIDTH-bit accumulators plus a DEPTH-stage valid-tagged delay line
//
// Ports:
//   clk  - sole clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - secret_accum_array_if.slave (accumulator controls/results, delay-line data/valid/pending)
// Build option:
//   SECRET_ACCUM_SAT_EN defined   -> accumulator saturates to all-ones on carry-out
//   SECRET_ACCUM_SAT_EN undefined -> accumulator wraps modulo 2^WIDTH
//   The sticky overflow flag behaves the same in both builds.
module secret_accum_array #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    secret_accum_array_if.slave   bus
);
    localparam int PW = $clog2(DEPTH + 1);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] acc_q, acc_d;
        logic             ovf_q, ovf_d;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] addend;

        assign addend = bus.accum_in[g*WIDTH +: WIDTH];
        // One extra bit so the carry-out is visible.
        assign sum    = {1'b0, acc_q} + {1'b0, addend};

        // Clear beats enable: the addend is dropped when both are set.
        always_comb begin
            acc_d = acc_q;
            ovf_d = ovf_q;
            if (bus.accum_clear[g]) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end else if (bus.accum_en[g]) begin
                ovf_d = ovf_q | sum[WIDTH];
`ifdef SECRET_ACCUM_SAT_EN
                acc_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                acc_d = sum[WIDTH-1:0];
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end

        assign bus.accum_out[g*WIDTH +: WIDTH]        = acc_q;
        assign bus.accum_bypass_out[g*WIDTH +: WIDTH] = bus.accum_bypass[g] ? addend : acc_q;
        assign bus.overflow[g]                        = ovf_q;
    end

    // Delay line: free-running shift of {valid, data}; data moves even when invalid.
    logic [DEPTH-1:0] dv_q, dv_d;
    logic [WIDTH-1:0] dd_q [DEPTH];
    logic [WIDTH-1:0] dd_d [DEPTH];
    logic [PW-1:0]    pend_q, pend_d;
    logic             beat_enter, beat_leave;

    assign beat_enter = bus.dly_valid_in;
    assign beat_leave = dv_q[DEPTH-1];

    always_comb begin
        dv_d    = dv_q;
        dd_d    = dd_q;
        dv_d[0] = bus.dly_valid_in;
        dd_d[0] = bus.dly_in;
        for (int s = 1; s < DEPTH; s++) begin
            dv_d[s] = dv_q[s-1];
            dd_d[s] = dd_q[s-1];
        end
        // Pending count tracks the valid popcount incrementally; entry and
        // exit on the same edge cancel out.
        pend_d = pend_q;
        if (beat_enter && !beat_leave) begin
            pend_d = pend_q + PW'(1);
        end else if (!beat_enter && beat_leave) begin
            pend_d = pend_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q   <= '0;
            pend_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dd_q[s] <= '0;
            end
        end else begin
            dv_q   <= dv_d;
            dd_q   <= dd_d;
            pend_q <= pend_d;
        end
    end

    assign bus.dly_out       = dd_q[DEPTH-1];
    assign bus.dly_valid_out = dv_q[DEPTH-1];
    assign bus.dly_pending   = pend_q;
endmodule

// File: tb/tb_secret_accum_array.sv
// tb/tb_secret_accum_array.sv - Self-checking bench for secret_accum_array (directed cases plus randomized parameter sweep)
module tb_secret_accum_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Sweep configurations (WIDTH, NCH, DEPTH) per index.
    function automatic int sw_w(input int k);
        case (k)
            0:       return 1;
            1:       return 33;
            2:       return 65;
            default: return 129;
        endcase
    endfunction
    function automatic int sw_n(input int k);
        return (k == 1 || k == 3) ? 3 : 1;
    endfunction
    function automatic int sw_d(input int k);
        return (k == 1 || k == 2) ? 5 : 1;
    endfunction
    function automatic logic [255:0] msk(input int w);
        return (256'(1) << w) - 256'(1);
    endfunction
    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Main instance: WIDTH 32, NCH 4, DEPTH 3
    secret_accum_array_if #(.WIDTH(32), .NCH(4), .DEPTH(3)) m_if ();
    secret_accum_array #(.WIDTH(32), .NCH(4), .DEPTH(3)) u_main (
        .clk(clk), .rst(rst), .bus(m_if.slave)
    );

    // Byte-wide instance for wrap/saturation boundaries
    secret_accum_array_if #(.WIDTH(8), .NCH(2), .DEPTH(2)) b_if ();
    secret_accum_array #(.WIDTH(8), .NCH(2), .DEPTH(2)) u_byte (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    // Sweep instances driven from generic wide vectors
    logic [767:0] sw_in  [4];
    logic [2:0]   sw_en  [4];
    logic [2:0]   sw_clr [4];
    logic [2:0]   sw_byp [4];
    logic [255:0] sw_dly [4];
    logic [3:0]   sw_dv;
    wire  [767:0] sw_out  [4];
    wire  [767:0] sw_bout [4];
    wire  [2:0]   sw_ovf  [4];
    wire  [255:0] sw_dout [4];
    wire  [3:0]   sw_dvo;
    wire  [3:0]   sw_pend [4];

    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int W = sw_w(k);
        localparam int N = sw_n(k);
        localparam int D = sw_d(k);
        secret_accum_array_if #(.WIDTH(W), .NCH(N), .DEPTH(D)) u_if ();
        secret_accum_array #(.WIDTH(W), .NCH(N), .DEPTH(D)) u_dut (
            .clk(clk), .rst(rst), .bus(u_if.slave)
        );
        assign u_if.accum_in     = sw_in[k][N*W-1:0];
        assign u_if.accum_en     = sw_en[k][N-1:0];
        assign u_if.accum_clear  = sw_clr[k][N-1:0];
        assign u_if.accum_bypass = sw_byp[k][N-1:0];
        assign u_if.dly_in       = sw_dly[k][W-1:0];
        assign u_if.dly_valid_in = sw_dv[k];
        assign sw_out[k]  = 768'(u_if.accum_out);
        assign sw_bout[k] = 768'(u_if.accum_bypass_out);
        assign sw_ovf[k]  = 3'(u_if.overflow);
        assign sw_dout[k] = 256'(u_if.dly_out);
        assign sw_dvo[k]  = u_if.dly_valid_out;
        assign sw_pend[k] = 4'(u_if.dly_pending);
    end

    // Reference model state for the sweep
    logic [255:0] mdl_acc [4][3];
    bit           mdl_ovf [4][3];
    bit           hist_v  [4][$];
    logic [255:0] hist_d  [4][$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_if.accum_in = '0; m_if.accum_en = '0; m_if.accum_clear = '0; m_if.accum_bypass = '0;
        m_if.dly_in = '0; m_if.dly_valid_in = 1'b0;
        b_if.accum_in = '0; b_if.accum_en = '0; b_if.accum_clear = '0; b_if.accum_bypass = '0;
        b_if.dly_in = '0; b_if.dly_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_in[k] = '0; sw_en[k] = '0; sw_clr[k] = '0; sw_byp[k] = '0; sw_dly[k] = '0;
        end
        sw_dv = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_if.accum_in = {$urandom, $urandom, $urandom, $urandom};
        m_if.accum_en = 4'($urandom); m_if.accum_clear = 4'($urandom);
        m_if.dly_in = $urandom; m_if.dly_valid_in = 1'b1;
        b_if.accum_in = 16'($urandom); b_if.accum_en = 2'b11; b_if.dly_valid_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_tests++; if (m_if.accum_out !== '0) begin n_fail++; $display("FAIL reset_accum_out got %h want 0", m_if.accum_out); end
        n_tests++; if (m_if.accum_bypass_out !== '0) begin n_fail++; $display("FAIL reset_bypass_out got %h want 0", m_if.accum_bypass_out); end
        n_tests++; if (m_if.overflow !== 4'h0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", m_if.overflow); end
        n_tests++; if (m_if.dly_out !== 32'h0) begin n_fail++; $display("FAIL reset_dly_out got %h want 0", m_if.dly_out); end
        n_tests++; if (m_if.dly_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_dly_valid got %b want 0", m_if.dly_valid_out); end
        n_tests++; if (m_if.dly_pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", m_if.dly_pending); end
        n_tests++; if (b_if.accum_out !== 16'h0 || b_if.overflow !== 2'b00) begin
            n_fail++; $display("FAIL reset_byte got %h/%b want 0/00", b_if.accum_out, b_if.overflow);
        end
    endtask

    task automatic test_accumulate();
        m_if.accum_en = 4'hF;
        for (int c = 0; c < 4; c++) m_if.accum_in[c*32 +: 32] = 32'(c + 1);
        for (int i = 0; i < 10; i++) tick();
        m_if.accum_en = 4'h0;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (m_if.accum_out[c*32 +: 32] !== 32'(10 * (c + 1))) begin
                n_fail++; $display("FAIL accum_ch%0d got %0d want %0d", c, m_if.accum_out[c*32 +: 32], 10 * (c + 1));
            end
        end
        m_if.accum_bypass = 4'b0100;
        m_if.accum_in[64 +: 32] = 32'h1234;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (m_if.accum_bypass_out[c*32 +: 32] !== ((c == 2) ? 32'h1234 : 32'(10 * (c + 1)))) begin
                n_fail++; $display("FAIL bypass_ch%0d got %h", c, m_if.accum_bypass_out[c*32 +: 32]);
            end
        end
        n_tests++; if (m_if.overflow !== 4'h0) begin n_fail++; $display("FAIL accum_overflow got %b want 0000", m_if.overflow); end
        idle_inputs();
    endtask

    task automatic test_clear_priority();
        m_if.accum_clear = 4'b0001;
        tick();
        m_if.accum_clear = 4'b0000; m_if.accum_en = 4'b0001; m_if.accum_in[0 +: 32] = 32'd7;
        tick();
        n_tests++; if (m_if.accum_out[0 +: 32] !== 32'd7) begin n_fail++; $display("FAIL clr_setup got %0d want 7", m_if.accum_out[0 +: 32]); end
        m_if.accum_clear = 4'b0001; m_if.accum_en = 4'b1001;
        m_if.accum_in[0 +: 32] = 32'd5; m_if.accum_in[96 +: 32] = 32'd1;
        tick();
        idle_inputs();
        n_tests++; if (m_if.accum_out[0 +: 32] !== 32'd0) begin n_fail++; $display("FAIL clr_prio_ch0 got %0d want 0", m_if.accum_out[0 +: 32]); end
        n_tests++; if (m_if.accum_out[32 +: 32] !== 32'd20) begin n_fail++; $display("FAIL clr_prio_ch1 got %0d want 20", m_if.accum_out[32 +: 32]); end
        n_tests++; if (m_if.accum_out[64 +: 32] !== 32'd30) begin n_fail++; $display("FAIL clr_prio_ch2 got %0d want 30", m_if.accum_out[64 +: 32]); end
        n_tests++; if (m_if.accum_out[96 +: 32] !== 32'd41) begin n_fail++; $display("FAIL clr_prio_ch3 got %0d want 41", m_if.accum_out[96 +: 32]); end
    endtask

    task automatic test_overflow();
        logic [1:0] t_en  [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        logic [1:0] t_clr [6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
        logic [7:0] t_in0 [6] = '{8'hFE, 8'h03, 8'h00, 8'h55, 8'hF0, 8'h20};
        logic [7:0] t_in1 [6] = '{8'hFF, 8'h00, 8'h01, 8'h55, 8'h00, 8'h77};
`ifdef SECRET_ACCUM_SAT_EN
        logic [7:0] e0 [6] = '{8'hFE, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'hFF};
        logic [7:0] e1 [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
`else
        logic [7:0] e0 [6] = '{8'hFE, 8'h01, 8'h01, 8'h00, 8'hF0, 8'h10};
        logic [7:0] e1 [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        logic [1:0] eo [6] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01};
        b_if.accum_clear = 2'b11;
        tick();
        for (int i = 0; i < 6; i++) begin
            b_if.accum_en = t_en[i]; b_if.accum_clear = t_clr[i];
            b_if.accum_in = {t_in1[i], t_in0[i]};
            tick();
            n_tests++;
            if (b_if.accum_out !== {e1[i], e0[i]} || b_if.overflow !== eo[i]) begin
                n_fail++;
                $display("FAIL ovf_step%0d got %h/%b want %h/%b", i, b_if.accum_out, b_if.overflow, {e1[i], e0[i]}, eo[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_delay();
        bit         vin  [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
        logic [31:0] din [8] = '{32'hA, 32'hB, 32'h5A5A, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0};
        bit         ev   [8] = '{0, 0, 1, 1, 0, 1, 0, 0};
        logic [31:0] ed  [8] = '{32'h0, 32'h0, 32'hA, 32'hB, 32'h0, 32'hC, 32'h0, 32'h0};
        int         ep   [8] = '{1, 2, 2, 2, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            m_if.dly_valid_in = vin[i]; m_if.dly_in = din[i];
            tick();
            n_tests++;
            if (m_if.dly_valid_out !== ev[i] || m_if.dly_pending !== 2'(ep[i])) begin
                n_fail++;
                $display("FAIL dly_cyc%0d valid/pending got %b/%0d want %b/%0d", i + 1, m_if.dly_valid_out, m_if.dly_pending, ev[i], ep[i]);
            end
            if (ev[i]) begin
                n_tests++;
                if (m_if.dly_out !== ed[i]) begin n_fail++; $display("FAIL dly_data_cyc%0d got %h want %h", i + 1, m_if.dly_out, ed[i]); end
            end
        end
        // Reset with two beats in flight: neither may ever emerge.
        m_if.dly_valid_in = 1'b1; m_if.dly_in = 32'h11;
        tick();
        m_if.dly_in = 32'h22;
        tick();
        m_if.dly_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (m_if.dly_pending !== 2'd0) begin n_fail++; $display("FAIL dly_rst_pending got %0d want 0", m_if.dly_pending); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (m_if.dly_valid_out !== 1'b0) begin n_fail++; $display("FAIL dly_rst_leak cyc%0d got 1 want 0", i); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sweep();
        logic [255:0] add [4][3];
        bit           en_r [4][3];
        bit           clr_r [4][3];
        bit           byp_r [4][3];
        bit           dv_r [4];
        logic [255:0] dd_r [4];
        logic [767:0] pk;
        logic [256:0] s;
        logic [255:0] got, expv;
        int           w, n, d, pc;
        bit           do_rst;
        for (int cyc = 0; cyc < 400; cyc++) begin
            do_rst = (cyc == 0) || ($urandom_range(0, 39) == 0);
            for (int k = 0; k < 4; k++) begin
                w = sw_w(k); n = sw_n(k);
                pk = '0;
                for (int c = 0; c < 3; c++) begin
                    add[k][c]   = ($urandom_range(0, 3) == 0) ? '0 : (rand256() & msk(w));
                    en_r[k][c]  = ($urandom_range(0, 3) != 0);
                    clr_r[k][c] = ($urandom_range(0, 15) == 0);
                    byp_r[k][c] = 1'($urandom_range(0, 1));
                    if (c < n) pk = pk | (768'(add[k][c]) << (c * w));
                end
                sw_in[k]  = pk;
                sw_en[k]  = {en_r[k][2], en_r[k][1], en_r[k][0]};
                sw_clr[k] = {clr_r[k][2], clr_r[k][1], clr_r[k][0]};
                sw_byp[k] = {byp_r[k][2], byp_r[k][1], byp_r[k][0]};
                dv_r[k]   = 1'($urandom_range(0, 1));
                dd_r[k]   = rand256() & msk(w);
                sw_dly[k] = dd_r[k];
                sw_dv[k]  = dv_r[k];
            end
            rst = do_rst;
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                w = sw_w(k); d = sw_d(k);
                if (do_rst) begin
                    for (int c = 0; c < 3; c++) begin mdl_acc[k][c] = '0; mdl_ovf[k][c] = 1'b0; end
                    hist_v[k].delete(); hist_d[k].delete();
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        if (clr_r[k][c]) begin
                            mdl_acc[k][c] = '0; mdl_ovf[k][c] = 1'b0;
                        end else if (en_r[k][c]) begin
                            s = 257'(mdl_acc[k][c]) + 257'(add[k][c]);
                            if ((s >> w) != 0) begin
                                mdl_ovf[k][c] = 1'b1;
`ifdef SECRET_ACCUM_SAT_EN
                                mdl_acc[k][c] = msk(w);
`else
                                mdl_acc[k][c] = s[255:0] & msk(w);
`endif
                            end else begin
                                mdl_acc[k][c] = s[255:0];
                            end
                        end
                    end
                    hist_v[k].push_back(dv_r[k]); hist_d[k].push_back(dd_r[k]);
                    if (hist_v[k].size() > d) begin void'(hist_v[k].pop_front()); void'(hist_d[k].pop_front()); end
                end
            end
            #1;
            rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w = sw_w(k); n = sw_n(k); d = sw_d(k);
                for (int c = 0; c < n; c++) begin
                    got = 256'((sw_out[k] >> (c * w))) & msk(w);
                    n_tests++;
                    if (got !== mdl_acc[k][c]) begin n_fail++; $display("FAIL sweep%0d_acc_ch%0d cyc%0d got %h want %h", k, c, cyc, got, mdl_acc[k][c]); end
                    got  = 256'((sw_bout[k] >> (c * w))) & msk(w);
                    expv = byp_r[k][c] ? add[k][c] : mdl_acc[k][c];
                    n_tests++;
                    if (got !== expv) begin n_fail++; $display("FAIL sweep%0d_byp_ch%0d cyc%0d got %h want %h", k, c, cyc, got, expv); end
                    n_tests++;
                    if (sw_ovf[k][c] !== mdl_ovf[k][c]) begin n_fail++; $display("FAIL sweep%0d_ovf_ch%0d cyc%0d got %b want %b", k, c, cyc, sw_ovf[k][c], mdl_ovf[k][c]); end
                end
                pc = 0;
                for (int i = 0; i < hist_v[k].size(); i++) pc += int'(hist_v[k][i]);
                expv = (hist_d[k].size() == d) ? hist_d[k][0] : '0;
                n_tests++;
                if (sw_dvo[k] !== ((hist_v[k].size() == d) ? hist_v[k][0] : 1'b0) || sw_dout[k] !== expv) begin
                    n_fail++; $display("FAIL sweep%0d_dly cyc%0d got %b/%h want data %h", k, cyc, sw_dvo[k], sw_dout[k], expv);
                end
                n_tests++;
                if (sw_pend[k] !== 4'(pc)) begin n_fail++; $display("FAIL sweep%0d_pending cyc%0d got %0d want %0d", k, cyc, sw_pend[k], pc); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_accumulate();
        test_clear_priority();
        test_overflow();
        test_delay();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    final begin
        for (int c = 0; c < 4; c++) begin
            $display("[TB] final ch%0d accum_q=%h overflow=%b", c, m_if.accum_out[c*32 +: 32], m_if.overflow[c]);
        end
    end
endmodule

// File: doc/secret_accum_array.md
# secret_accum_array

Parametrised multi-channel accumulator for the DPI protected-library regression suite. Provides NCH independent WIDTH-bit accumulators with per-channel enable, clear and combinational bypass, plus a DEPTH-stage valid-tagged delay pipeline. Together these exercise purely sequential, mixed combinational/sequential and multi-cycle paths across a protected-library boundary at arbitrary widths. It is the generalised successor to the single 32-bit accumulator used in the existing protected-library tests, and sits behind the same wrapper.

## Interface
- WIDTH, 32, accumulator and delay-line data width; legal range 1..256
- NCH, 4, number of accumulator channels; legal range 1..16
- DEPTH, 3, delay-pipeline stages; legal range 1..16
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- accum_in  input  NCH*WIDTH  per-channel addend; channel i occupies bits [i*WIDTH +: WIDTH]
- accum_en  input  NCH  per-channel accumulate enable
- accum_clear  input  NCH  per-channel synchronous clear
- accum_bypass  input  NCH  per-channel bypass select
- accum_out  output  NCH*WIDTH  registered accumulator values
- accum_bypass_out  output  NCH*WIDTH  per channel: accum_bypass[i] ? accum_in[i] : accum_q[i] (combinational)
- overflow  output  NCH  sticky per-channel carry-out flag
- dly_in  input  WIDTH  delay-pipeline data
- dly_valid_in  input  1  delay-pipeline valid
- dly_out  output  WIDTH  data from the last stage
- dly_valid_out  output  1  valid from the last stage
- dly_pending  output  $clog2(DEPTH+1)  count of valid beats held in the pipeline

## Operation
- Per-channel update priority on each posedge: rst > accum_clear[i] > accum_en[i] > hold.
- rst: every accum_q and overflow bit becomes 0.
- accum_clear[i] = 1: accum_q[i] <= 0 and overflow[i] <= 0. This applies even when accum_en[i] = 1; the addend is discarded.
- accum_en[i] = 1: sum = accum_q[i] + accum_in[i], computed at WIDTH+1 bits. If sum[WIDTH] = 1, overflow[i] <= 1.
  - Without saturation: accum_q[i] <= sum[WIDTH-1:0] (modulo 2^WIDTH).
  - With saturation: accum_q[i] <= all-ones.
- overflow is sticky. Only rst or accum_clear[i] clear it.
- accum_bypass_out has no state and depends on the current cycle's accum_bypass, accum_in and accum_q.
- Channels are fully independent; no cross-channel interaction.
- Delay pipeline:
  - DEPTH stages of {valid, data} shift every cycle; no stall.
  - Stage 0 loads {dly_valid_in, dly_in}.
  - The data register captures dly_in regardless of valid. Downstream logic ignores data when valid = 0.
  - dly_pending = popcount of the stage valid bits. It is maintained as a counter: +1 on valid entering, −1 on valid leaving, unchanged when both or neither occur.
- Reset mid-operation: all in-flight delay beats are dropped. The cycle after rst, the pipeline is empty and dly_pending = 0.
- A final-time message reports each channel's accum_q and overflow.

## Timing
- Reset values: accum_out = 0, overflow = 0, dly_out = 0, dly_valid_out = 0, dly_pending = 0.
- accum_out: 1-cycle latency from accum_en/accum_in to the updated value.
- accum_bypass_out: 0-cycle latency when in bypass; otherwise it reflects accum_q.
- dly_out/dly_valid_out: exactly DEPTH cycles after the inputs are sampled.
- dly_pending updates on the same edge that moves the valids.
- With DEPTH = 1, simultaneous entry and exit leaves dly_pending unchanged.
- Wrap boundary, WIDTH = 8: 0xFF + 0x01 gives 0x00 with overflow set.
- Saturation boundary, WIDTH = 8: 0xF0 + 0x20 gives 0xFF; 0xFF + 0x00 gives 0xFF with no new overflow.

## Configuration
- SECRET_ACCUM_SAT_EN defined: the accumulator saturates at 2^WIDTH−1 on carry-out.
- SECRET_ACCUM_SAT_EN undefined: the accumulator wraps modulo 2^WIDTH.
- overflow flag behaviour is identical in both builds.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> all outputs 0 the following cycle, including dly_pending = 0.
- Accumulate: WIDTH = 32, NCH = 4, channel i adds i+1 for 10 cycles with en = 1 -> accum_out channels = 10, 20, 30, 40. Bypass on channel 2 with accum_in = 0x1234 -> accum_bypass_out ch2 = 0x1234 in the same cycle; other channels show their accum_q.
- Overflow, WIDTH = 8, accumulator at 0xFE, add 0x03:
  - Wrap build: 0x01 with overflow = 1.
  - SAT_EN build: 0xFF with overflow = 1.
  - Then clear -> accumulator 0, overflow 0.
- Clear priority: clear = 1 and en = 1 with accum_in = 5 on an accumulator at 7 -> accum_out = 0 next cycle; channels not cleared are unaffected.
- Delay line, DEPTH = 3: valid beats 0xA, 0xB, then a bubble, then 0xC -> outputs at cycles 3, 4 and 6 in order; dly_pending peaks at 2. Assert rst while 2 beats are in flight -> dly_valid_out never pulses for them.
- Parameter sweep: WIDTH ∈ {1, 33, 65, 129}, NCH ∈ {1, 3}, DEPTH ∈ {1, 5} -> random accumulation matches a reference model every cycle.
